fpnew_fma_arbiter: RTL and testbench

Shares one pipelined fpnew_fma instance between NumReq requesters, such as integer-core FP ports or vector lanes.
- Issue side: round-robin arbitration over valid/ready operand channels.
- Return side: a requester-index FIFO routes in-order FMA results back to the requester that issued each operation.
- Bounds in-flight operations to MaxOutstanding and flags protocol violations from the datapath side.
Sits between the requesters and the fpnew_fma datapath, in the FPU's operation-group layer.

---
 rtl/fpnew_fma_arbiter.sv | 112 +++++++++++
 tb/tb_fpnew_fma_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_fma_arbiter.sv
// Shares one pipelined FMA among NumReq requesters: round-robin issue with grant lock,
// and an owner-index FIFO that steers in-order results back to the requester that issued them.
module fpnew_fma_arbiter #(
  parameter int unsigned NumReq         = 4,
  parameter int unsigned Width          = 64,
  parameter int unsigned OpBits         = 4,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                               clk_i,
  input  logic                               rst_ni,
  input  logic [NumReq-1:0]                  req_valid_i,
  output logic [NumReq-1:0]                  req_ready_o,
  input  logic [NumReq*3*Width-1:0]          req_operands_i,
  input  logic [NumReq*OpBits-1:0]           req_op_i,
  output logic                               fma_in_valid_o,
  input  logic                               fma_in_ready_i,
  output logic [3*Width-1:0]                 fma_operands_o,
  output logic [OpBits-1:0]                  fma_op_o,
  input  logic                               fma_out_valid_i,
  output logic                               fma_out_ready_o,
  input  logic [Width-1:0]                   fma_result_i,
  output logic [NumReq-1:0]                  rsp_valid_o,
  input  logic [NumReq-1:0]                  rsp_ready_i,
  output logic [Width-1:0]                   rsp_result_o,
  output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
  output logic                               err_o
);
  localparam int unsigned IdxW = $clog2(NumReq);
  localparam int unsigned PtrW = (MaxOutstanding > 1) ? $clog2(MaxOutstanding) : 1;
  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  logic [IdxW-1:0] rr_q, lock_idx_q, grant, cand, head;
  logic            lock_q, err_q;
  logic [MaxOutstanding-1:0][IdxW-1:0] fifo_q;
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, push, pop, lock_drop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(MaxOutstanding - 1)) ? '0 : p + 1'b1;
  endfunction

  // Circular search from rr_q: iterate farthest-first so the nearest valid wins.
  always_comb begin
    grant = rr_q;
    cand  = '0;
    if (lock_q) begin
      grant = lock_idx_q;
    end else begin
      for (int k = NumReq - 1; k >= 0; k--) begin
        cand = IdxW'((int'(rr_q) + k) % NumReq);
        if (req_valid_i[cand]) grant = cand;
      end
    end
  end

  assign full      = (count_q == CntW'(MaxOutstanding));
  assign empty     = (count_q == '0);
  assign head      = fifo_q[rd_ptr_q];
  assign lock_drop = lock_q & ~req_valid_i[lock_idx_q];

  assign fma_in_valid_o  = rst_ni & req_valid_i[grant] & ~full;
  assign fma_operands_o  = req_operands_i[grant*3*Width +: 3*Width];
  assign fma_op_o        = req_op_i[grant*OpBits +: OpBits];
  assign push            = fma_in_valid_o & fma_in_ready_i;

  assign fma_out_ready_o = rst_ni & rsp_ready_i[head] & ~empty;
  assign pop             = fma_out_valid_i & fma_out_ready_o;
  assign rsp_result_o    = fma_result_i;
  assign outstanding_o   = count_q;
  assign err_o           = err_q;

  always_comb begin
    req_ready_o = '0;
    rsp_valid_o = '0;
    if (push) req_ready_o[grant] = 1'b1;
    if (rst_ni && fma_out_valid_i && !empty) rsp_valid_o[head] = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q       <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
        rr_q     <= (grant == IdxW'(NumReq - 1)) ? '0 : grant + 1'b1;
        lock_q   <= 1'b0;
      end else if (fma_in_valid_o) begin
        // Stalled by the FMA: hold this grant so operands stay stable until accepted.
        lock_q     <= 1'b1;
        lock_idx_q <= grant;
      end else if (lock_drop) begin
        lock_q <= 1'b0;
      end
      if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
      if (lock_drop || (fma_out_valid_i && empty)) err_q <= 1'b1;
    end
  end

  // Owner storage needs no reset: entries are only read once counted in.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= grant;
  end
endmodule

// File: tb/tb_fpnew_fma_arbiter.sv
// Bench for fpnew_fma_arbiter: directed scenarios plus a randomized run against a
// queue-based owner model with an FMA stub that echoes a hash of the forwarded operands.
module tb_fpnew_fma_arbiter;
  localparam int N = 4, W = 64, OB = 4, MO = 4;

  logic              clk = 0, rst_n = 0;
  logic [N-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [N*3*W-1:0]  req_operands;
  logic [N*OB-1:0]   req_op;
  logic              in_valid, in_ready, out_valid, out_ready, err;
  logic [3*W-1:0]    fma_ops;
  logic [OB-1:0]     fma_op;
  logic [W-1:0]      fma_result, rsp_result;
  logic [2:0]        outstanding;

  int checks = 0, failures = 0;
  logic [3*W-1:0] ops [N];
  logic [OB-1:0]  opc [N];

  typedef struct { int owner; logic [W-1:0] res; } ent_t;

  fpnew_fma_arbiter #(.NumReq(N), .Width(W), .OpBits(OB), .MaxOutstanding(MO)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_operands_i(req_operands), .req_op_i(req_op),
    .fma_in_valid_o(in_valid), .fma_in_ready_i(in_ready),
    .fma_operands_o(fma_ops), .fma_op_o(fma_op),
    .fma_out_valid_i(out_valid), .fma_out_ready_o(out_ready), .fma_result_i(fma_result),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_result_o(rsp_result),
    .outstanding_o(outstanding), .err_o(err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] fma_hash(input logic [3*W-1:0] o);
    return o[63:0] ^ {o[126:64], o[127]} ^ {o[189:128], o[191:190]};
  endfunction

  task automatic tick; @(posedge clk); #1; endtask

  task automatic drive_reqs;
    for (int i = 0; i < N; i++) begin
      req_operands[i*3*W +: 3*W] = ops[i];
      req_op[i*OB +: OB] = opc[i];
    end
  endtask

  task automatic idle;
    req_valid = '0; in_ready = 0; out_valid = 0; fma_result = '0; rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      ops[i] = {64'(i + 3), 64'(i + 2), 64'(i + 1)};
      opc[i] = OB'(i);
    end
    drive_reqs();
  endtask

  task automatic test_reset;
    idle(); rst_n = 0;
    req_valid = '1; in_ready = 1; out_valid = 1; rsp_ready = '1; #1;
    checks++; if ({in_valid, req_ready, rsp_valid, out_ready} !== '0) begin
      failures++; $display("FAIL reset_outputs got=%0h exp=0", {in_valid, req_ready, rsp_valid, out_ready}); end
    tick(); tick();
    checks++; if (outstanding !== 0 || err !== 0) begin
      failures++; $display("FAIL reset_state got=%0d/%0d exp=0/0", outstanding, err); end
    idle(); rst_n = 1; tick();
  endtask

  task automatic test_fill;
    req_valid = '1; in_ready = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (req_ready !== 4'(1 << k) || fma_op !== 4'(k)) begin
        failures++; $display("FAIL fill_grant%0d got=%b/%0d exp=%b/%0d", k, req_ready, fma_op, 4'(1 << k), k); end
      tick();
    end
    #1;
    checks++; if (outstanding !== 4 || in_valid !== 0 || req_ready !== 0) begin
      failures++; $display("FAIL fill_full got=%0d/%b exp=4/0", outstanding, in_valid); end
    req_valid = '0;
  endtask

  task automatic test_returns;
    rsp_ready = '1; out_valid = 1;
    for (int k = 0; k < 4; k++) begin
      fma_result = 64'(10 + k); #1;
      checks++; if (rsp_valid !== 4'(1 << k) || rsp_result !== 64'(10 + k) || out_ready !== 1) begin
        failures++; $display("FAIL return%0d got=%b/%0h exp=%b/%0h", k, rsp_valid, rsp_result, 4'(1 << k), 10 + k); end
      tick();
    end
    out_valid = 0; #1;
    checks++; if (outstanding !== 0) begin
      failures++; $display("FAIL returns_drained got=%0d exp=0", outstanding); end
  endtask

  task automatic test_lock;
    req_valid = 4'b0100; in_ready = 0; #1;
    checks++; if (in_valid !== 1 || fma_ops !== ops[2]) begin
      failures++; $display("FAIL lock_first got=%b/%0h exp=1/%0h", in_valid, fma_ops, ops[2]); end
    tick();
    req_valid = 4'b0101;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (fma_ops !== ops[2] || fma_op !== 4'd2 || req_ready !== 0) begin
        failures++; $display("FAIL lock_hold%0d got=%0h exp=%0h", k, fma_ops, ops[2]); end
      tick();
    end
    in_ready = 1; #1;
    checks++; if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL lock_fire got=%b exp=0100", req_ready); end
    tick();
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL lock_next got=%b exp=0001", req_ready); end
    tick();
    req_valid = '0; in_ready = 0;
  endtask

  task automatic test_back_to_back;
    // FIFO holds owners 2,0 with rr at 1; two more issues fill it to 4.
    req_valid = '1; in_ready = 1; tick(); tick();
    out_valid = 1; fma_result = 64'h55; rsp_ready = '1; #1;
    checks++; if (in_valid !== 0 || rsp_valid !== 4'b0100 || out_ready !== 1) begin
      failures++; $display("FAIL full_pop got=%b/%b exp=0/0100", in_valid, rsp_valid); end
    tick();
    out_valid = 0; #1;
    checks++; if (outstanding !== 3 || in_valid !== 1 || req_ready !== 4'b1000) begin
      failures++; $display("FAIL after_pop got=%0d/%b exp=3/1000", outstanding, req_ready); end
    tick();
    req_valid = '0; out_valid = 1;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks++; if (rsp_valid !== 4'(1 << k)) begin
        failures++; $display("FAIL drain%0d got=%b exp=%b", k, rsp_valid, 4'(1 << k)); end
      tick();
    end
    req_valid = 4'b0001; #1;
    checks++; if (req_ready !== 4'b0001 || rsp_valid !== 4'b0100) begin
      failures++; $display("FAIL push_pop got=%b/%b exp=0001/0100", req_ready, rsp_valid); end
    tick();
    req_valid = '0; out_valid = 0; #1;
    checks++; if (outstanding !== 2) begin
      failures++; $display("FAIL push_pop_count got=%0d exp=2", outstanding); end
  endtask

  task automatic test_backpressure_err;
    out_valid = 1; fma_result = 64'h77; rsp_ready = 4'b0111; #1;
    checks++; if (out_ready !== 0 || rsp_valid !== 4'b1000 || rsp_result !== 64'h77) begin
      failures++; $display("FAIL bp_hold got=%b/%b exp=0/1000", out_ready, rsp_valid); end
    tick(); tick();
    checks++; if (outstanding !== 2) begin
      failures++; $display("FAIL bp_nopop got=%0d exp=2", outstanding); end
    rsp_ready = '1; tick(); tick();
    out_valid = 0; #1;
    checks++; if (outstanding !== 0 || err !== 0) begin
      failures++; $display("FAIL bp_drain got=%0d/%b exp=0/0", outstanding, err); end
    out_valid = 1; #1;
    checks++; if (out_ready !== 0 || rsp_valid !== 0) begin
      failures++; $display("FAIL spurious_blocked got=%b/%b exp=0/0", out_ready, rsp_valid); end
    tick();
    out_valid = 0; #1;
    checks++; if (err !== 1) begin
      failures++; $display("FAIL err_set got=%b exp=1", err); end
    tick(); tick();
    checks++; if (err !== 1) begin
      failures++; $display("FAIL err_sticky got=%b exp=1", err); end
  endtask

  task automatic test_reset_mid;
    // Grants 1,2,0 leave rr at 1, so only a real reset lets req 0 win next.
    req_valid = 4'b0111; in_ready = 1; tick(); tick(); tick();
    req_valid = '0; #1;
    checks++; if (outstanding !== 3) begin
      failures++; $display("FAIL mid_inflight got=%0d exp=3", outstanding); end
    rst_n = 0; tick();
    rst_n = 1; req_valid = '1; in_ready = 0; #1;
    checks++; if (outstanding !== 0 || err !== 0 || in_valid !== 1 || fma_op !== 4'd0) begin
      failures++; $display("FAIL mid_reset got=%0d/%b/%0d exp=0/0/0", outstanding, err, fma_op); end
    idle(); in_ready = 0; tick();
  endtask

  task automatic test_random;
    ent_t exp_q[$];
    logic [W-1:0] pipe[$];
    logic [N-1:0] pend, e_rdy, e_rsp;
    int rr, lock, g, h;
    logic e_in, e_out_rdy, e_err;
    idle(); rst_n = 0; tick(); rst_n = 1;
    rr = 0; lock = -1; e_err = 0; pend = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < N; i++)
        if (!pend[i] && $urandom_range(2) == 0) begin
          pend[i] = 1;
          ops[i] = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
          opc[i] = OB'($urandom);
        end
      drive_reqs();
      req_valid = pend;
      in_ready = ($urandom_range(3) != 0);
      out_valid = (pipe.size() > 0) && ($urandom_range(2) != 0);
      fma_result = (pipe.size() > 0) ? pipe[0] : {$urandom, $urandom};
      rsp_ready = N'($urandom);
      #1;
      g = -1;
      if (lock >= 0) g = lock;
      else for (int k = 0; k < N && g < 0; k++) if (pend[(rr + k) % N]) g = (rr + k) % N;
      e_in = (g >= 0) && pend[g] && (exp_q.size() < MO);
      e_rdy = (e_in && in_ready) ? N'(1 << g) : '0;
      h = (exp_q.size() > 0) ? exp_q[0].owner : 0;
      e_out_rdy = (exp_q.size() > 0) && rsp_ready[h];
      e_rsp = (out_valid && exp_q.size() > 0) ? N'(1 << h) : '0;
      checks++; if (in_valid !== e_in || req_ready !== e_rdy) begin
        failures++; $display("FAIL rnd_issue c%0d got=%b/%b exp=%b/%b", cyc, in_valid, req_ready, e_in, e_rdy); end
      if (e_in) begin
        checks++; if (fma_ops !== ops[g] || fma_op !== opc[g]) begin
          failures++; $display("FAIL rnd_ops c%0d got=%0h exp=%0h", cyc, fma_ops, ops[g]); end
      end
      checks++; if (rsp_valid !== e_rsp || out_ready !== e_out_rdy) begin
        failures++; $display("FAIL rnd_ret c%0d got=%b/%b exp=%b/%b", cyc, rsp_valid, out_ready, e_rsp, e_out_rdy); end
      checks++; if (outstanding !== 3'(exp_q.size()) || err !== e_err) begin
        failures++; $display("FAIL rnd_state c%0d got=%0d/%b exp=%0d/%b", cyc, outstanding, err, exp_q.size(), e_err); end
      if (out_valid && e_out_rdy) begin
        checks++; if (rsp_result !== exp_q[0].res) begin
          failures++; $display("FAIL rnd_result c%0d got=%0h exp=%0h", cyc, rsp_result, exp_q[0].res); end
        void'(exp_q.pop_front());
        void'(pipe.pop_front());
      end
      if (e_in && in_ready) begin
        exp_q.push_back('{owner: g, res: fma_hash(ops[g])});
        pipe.push_back(fma_hash(fma_ops));
        pend[g] = 0; rr = (g + 1) % N; lock = -1;
      end else if (e_in) lock = g;
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_returns();
    test_lock();
    test_back_to_back();
    test_backpressure_err();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
